accum_scheduler: RTL and testbench
==================================

ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one accumulator; legal range 2..8.
REQ-002 Parameter W, default 32: operand and sum width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester beat valid.
REQ-006 req_last  input  N_REQ  per-requester flag marking the final beat of a transaction.
REQ-007 req_up  input  N_REQ*W  per-requester addend; slice i is bits [i*W +: W].
REQ-008 req_down  input  N_REQ*W  per-requester subtrahend; slice layout is the same as req_up.
REQ-009 req_ready  output  N_REQ  per-requester beat accept; one-hot or zero.
REQ-010 rsp_valid  output  1  one-cycle pulse carrying a transaction result.
REQ-011 rsp_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-012 rsp_sum  output  W  final accumulated value.
REQ-013 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL select a winner round-robin, starting the search at last_grant+1 modulo N_REQ. It SHALL register the winner as grant and enter RUN at the next edge.
REQ-016 In IDLE, req_ready SHALL be all zero.
REQ-017 In RUN, req_ready[grant] SHALL equal req_valid[grant] combinationally, and all other ready bits SHALL be 0. A beat is accepted when valid and ready are both high.
REQ-018 The first accepted beat of a transaction SHALL load acc <= up - down.
REQ-019 Each later accepted beat SHALL update acc <= acc + up - down.
REQ-020 All accumulator arithmetic SHALL be modulo 2^W and full W bits; no truncation and no saturation.
REQ-021 A cycle in RUN with no accepted beat SHALL leave acc unchanged. The grant SHALL be held indefinitely; there is no timeout and no preemption.
REQ-022 An accepted beat with req_last high SHALL move the FSM to RESP. A single-beat transaction (first beat also last) SHALL be legal.
REQ-023 In RESP, the block SHALL for exactly one cycle drive rsp_valid=1, rsp_id=grant and rsp_sum equal to the final acc.
REQ-024 In RESP, the block SHALL set last_grant <= grant and return to IDLE.
REQ-025 When the FSM is not in RESP, rsp_valid SHALL be 0. rsp_id and rsp_sum SHALL hold their last driven values.
REQ-026 Latency SHALL be: grant one cycle after valid is seen in IDLE; rsp_valid one cycle after the last beat is accepted.
REQ-027 Minimum transaction occupancy SHALL be L+2 cycles for L beats. A new grant cannot start until the cycle after RESP.
REQ-028 Requests from non-granted requesters SHALL be ignored, not lost. They remain pending while their valid stays high.
REQ-029 When all requesters are continuously valid, grants SHALL rotate 0,1,...,N_REQ-1,0.
REQ-030 Changes to req_up, req_down or req_last while ready is low SHALL have no effect.

Reset
REQ-031 While reset is high, the block SHALL hold state=IDLE, acc=0, grant=0, last_grant=N_REQ-1, rsp_valid=0, rsp_id=0, rsp_sum=0 and busy=0.
REQ-032 Reset asserted mid-RUN or mid-RESP SHALL abort the transaction with no response issued. Reset priority SHALL override beat acceptance in the same cycle.
REQ-033 After reset deassertion, the first grant SHALL go to the lowest-index valid requester.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, RUN, RESP) and the default constants N_REQ_DEF=4 and W_DEF=32.
REQ-035 The accumulator datapath SHALL be one sub-module, accum_core. Its ports SHALL be clk, reset, load, en, up, down and sum. It SHALL implement REQ-018 to REQ-020 with a W-bit register.
REQ-036 The round-robin winner logic SHALL be combinational inside accum_scheduler; no second sub-module.

Verification
REQ-037 Single requester: requester 1 sends beats (10,3), (5,0), (0,2, last). Required: rsp_valid with rsp_id=1 and rsp_sum=10 one cycle after beat 3 is accepted, and busy low the next cycle.
REQ-038 Contention: all four valid from reset, each sending one beat (i+1,0, last). Required: responses in id order 0,1,2,3 with sums 1,2,3,4, spaced 3 cycles apart.
REQ-039 Wrap-around: beats (0,1) then (0,0, last). Required: rsp_sum=0xFFFFFFFF. Then beats (0xFFFFFFFF,0) then (2,0, last). Required: rsp_sum=1.
REQ-040 Stall: the granted requester drops valid for 5 cycles mid-transaction while others stay valid. Required: grant held, other ready bits stay 0, and sum unaffected by the stall.
REQ-041 Reset mid-RUN after 2 beats. Required: no rsp_valid, acc=0, and the next transaction's sum excludes the aborted beats.
REQ-042 Fairness: requesters 0 and 2 continuously valid for 4 transactions. Required: grant order 0,2,0,2 with no starvation.

Source files
------------

// File: rtl/accum_scheduler_pkg.sv
// rtl/accum_scheduler_pkg.sv - shared FSM state type and default sizing constants
package accum_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 32;

endpackage

// File: rtl/accum_scheduler_if.sv
// rtl/accum_scheduler_if.sv - requester beat bus and result bus of the shared accumulator
interface accum_scheduler_if
    import accum_scheduler_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ*W-1:0] req_up;
    logic [N_REQ*W-1:0] req_down;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_sum;
    logic               busy;

    modport master (
        output req_valid, req_last, req_up, req_down,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req_valid, req_last, req_up, req_down,
        output req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );

endinterface

// File: rtl/accum_core.sv
// rtl/accum_core.sv - W-bit wrap-around accumulator; load starts a new sum, en applies a beat
module accum_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] up,
    input  logic [W-1:0] down,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (en) begin
            if (load) begin
                sum <= up - down;
            end else begin
                sum <= sum + up - down;
            end
        end
    end

endmodule

// File: rtl/accum_scheduler.sv
// rtl/accum_scheduler.sv - round-robin scheduler granting one requester at a time to a shared accumulator
module accum_scheduler
    import accum_scheduler_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    accum_scheduler_if.slave  bus
);

    localparam int IDW = $clog2(N_REQ);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic           first;
    logic           beat;
    logic [W-1:0]   up_sel;
    logic [W-1:0]   down_sel;
    logic [W-1:0]   acc;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_sum_q;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign up_sel   = bus.req_up[grant*W +: W];
    assign down_sel = bus.req_down[grant*W +: W];
    assign beat     = (state == RUN) && bus.req_valid[grant];

    always_comb begin
        bus.req_ready = '0;
        if (state == RUN) begin
            bus.req_ready[grant] = bus.req_valid[grant];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = RUN;
            RUN:     if (beat && bus.req_last[grant]) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(N_REQ - 1);
            first      <= 1'b0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant <= winner;
                first <= 1'b1;
            end
            if (beat) begin
                first <= 1'b0;
            end
            if (state == RESP) begin
                last_grant <= grant;
                rsp_id_q   <= grant;
                rsp_sum_q  <= acc;
            end
        end
    end

    accum_core #(.W(W)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (first),
        .en    (beat),
        .up    (up_sel),
        .down  (down_sel),
        .sum   (acc)
    );

    // Result is live during RESP and then held by the shadow registers.
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = (state == RESP) ? grant : rsp_id_q;
    assign bus.rsp_sum   = (state == RESP) ? acc : rsp_sum_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_accum_scheduler.sv
// tb/tb_accum_scheduler.sv - scoreboard bench for accum_scheduler with randomized beats
module tb_accum_scheduler;
    import accum_scheduler_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    accum_scheduler_if #(.N_REQ(N), .W(W)) bus();

    accum_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] up_q[N][$];
    logic [W-1:0] down_q[N][$];
    bit           last_q[N][$];
    logic [W-1:0] txn_sum[N];
    logic [W-1:0] exp_sum[N][$];
    int           exp_id[$];
    int           rsp_ids[$];
    int           rsp_cycs[$];
    logic [W-1:0] rsp_sums[$];
    int           last_acc_cyc[N];
    int           acc_cnt[N];
    int           model_last;
    int           cur_grant;
    bit           expect_idle;
    int           stall_pct;
    logic [N-1:0] force_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int id, input logic [W-1:0] u, input logic [W-1:0] d, input bit l);
        up_q[id].push_back(u);
        down_q[id].push_back(d);
        last_q[id].push_back(l);
        txn_sum[id] = txn_sum[id] + u - d;
        if (l) begin
            exp_sum[id].push_back(txn_sum[id]);
            txn_sum[id] = '0;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            up_q[i].delete();
            down_q[i].delete();
            last_q[i].delete();
            exp_sum[i].delete();
            txn_sum[i] = '0;
            acc_cnt[i] = 0;
            last_acc_cyc[i] = 0;
        end
        exp_id.delete();
        model_last = N - 1;
        cur_grant = -1;
    endtask

    task automatic clear_logs();
        rsp_ids.delete();
        rsp_cycs.delete();
        rsp_sums.delete();
    endtask

    function automatic bit pending();
        bit p = (exp_id.size() != 0);
        for (int i = 0; i < N; i++) begin
            if (up_q[i].size() != 0 || exp_sum[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    // One cycle of stimulus: offered beats come from the queues, idle lanes carry junk.
    task automatic step();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N-1:0]   rdy;
        logic [N*W-1:0] u;
        logic [N*W-1:0] d;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (up_q[i].size() > 0 && !force_low[i] && $urandom_range(0, 99) >= stall_pct) begin
                v[i] = 1'b1;
                u[i*W +: W] = up_q[i][0];
                d[i*W +: W] = down_q[i][0];
                l[i] = last_q[i][0];
            end else begin
                v[i] = 1'b0;
                u[i*W +: W] = $urandom;
                d[i*W +: W] = $urandom;
                l[i] = 1'($urandom_range(0, 1));
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_up    = u;
        bus.req_down  = d;
        #1;
        rdy = bus.req_ready;
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && v[i]) begin
                acc_cnt[i]++;
                if (last_q[i][0]) last_acc_cyc[i] = cyc + 1;
                void'(up_q[i].pop_front());
                void'(down_q[i].pop_front());
                void'(last_q[i].pop_front());
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (pending() && guard < 3000) begin
            step();
            guard++;
        end
        check("drain_timeout", 64'(pending()), 64'd0);
        repeat (2) step();
    endtask

    task automatic do_reset(input int n, input bit keep_inputs);
        @(negedge clk);
        reset = 1'b1;
        if (!keep_inputs) bus.req_valid = '0;
        clear_model();
        repeat (n) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_sum", 64'(bus.rsp_sum), 64'd0);
        check("rst_acc", 64'(dut.u_core.sum), 64'd0);
        reset = 1'b0;
        clear_logs();
    endtask

    // Monitor: predicts each grant from the request pattern and scores every response.
    initial begin
        logic [N-1:0] exp_rdy;
        int id;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                expect_idle = 1'b0;
                continue;
            end
            if (expect_idle) begin
                check("busy_after_rsp", 64'(bus.busy), 64'd0);
                expect_idle = 1'b0;
            end
            exp_rdy = '0;
            if (bus.busy && !bus.rsp_valid && cur_grant >= 0)
                exp_rdy = bus.req_valid & (N'(1) << cur_grant);
            check("ready", 64'(bus.req_ready), 64'(exp_rdy));
            if (bus.rsp_valid) begin
                if (exp_id.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    id = exp_id.pop_front();
                    check("rsp_id", 64'(bus.rsp_id), 64'(id));
                    check("rsp_latency", 64'(cyc), 64'(last_acc_cyc[id]));
                    if (exp_sum[id].size() > 0)
                        check("rsp_sum", 64'(bus.rsp_sum), 64'(exp_sum[id].pop_front()));
                    else
                        check("rsp_sum_expected", 64'(exp_sum[id].size()), 64'd1);
                end
                rsp_ids.push_back(int'(bus.rsp_id));
                rsp_cycs.push_back(cyc);
                rsp_sums.push_back(bus.rsp_sum);
                expect_idle = 1'b1;
            end
            if (!bus.busy && (|bus.req_valid)) begin
                for (int k = 1; k <= N; k++) begin
                    id = (model_last + k) % N;
                    if (bus.req_valid[id]) break;
                end
                exp_id.push_back(id);
                model_last = id;
                cur_grant = id;
            end
        end
    end

    initial begin
        int id;
        int len;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_up    = '0;
        bus.req_down  = '0;
        stall_pct = 0;
        force_low = '0;
        expect_idle = 1'b0;
        clear_model();
        do_reset(3, 1'b0);

        // Single requester, three beats.
        push_beat(1, 32'd10, 32'd3, 1'b0);
        push_beat(1, 32'd5,  32'd0, 1'b0);
        push_beat(1, 32'd0,  32'd2, 1'b1);
        drain();
        check("single_count", 64'(rsp_sums.size()), 64'd1);
        if (rsp_sums.size() == 1) check("single_sum", 64'(rsp_sums[0]), 64'd10);

        // Contention from reset: ids in order, three cycles apart.
        do_reset(2, 1'b0);
        for (int i = 0; i < N; i++) push_beat(i, W'(i + 1), '0, 1'b1);
        drain();
        check("cont_count", 64'(rsp_ids.size()), 64'(N));
        for (int i = 0; i < rsp_ids.size(); i++) begin
            check("cont_id", 64'(rsp_ids[i]), 64'(i));
            check("cont_sum", 64'(rsp_sums[i]), 64'(i + 1));
            if (i > 0) check("cont_spacing", 64'(rsp_cycs[i] - rsp_cycs[i-1]), 64'd3);
        end

        // Modulo wrap in both directions.
        clear_logs();
        push_beat(2, 32'd0, 32'd1, 1'b0);
        push_beat(2, 32'd0, 32'd0, 1'b1);
        push_beat(2, 32'hFFFF_FFFF, 32'd0, 1'b0);
        push_beat(2, 32'd2, 32'd0, 1'b1);
        drain();
        check("wrap_count", 64'(rsp_sums.size()), 64'd2);
        if (rsp_sums.size() == 2) begin
            check("wrap_under", 64'(rsp_sums[0]), 64'hFFFF_FFFF);
            check("wrap_over", 64'(rsp_sums[1]), 64'd1);
        end

        // Granted requester stalls five cycles while others wait.
        do_reset(2, 1'b0);
        for (int i = 0; i < 3; i++)
            for (int b = 0; b < 3; b++) push_beat(i, $urandom, $urandom, b == 2);
        for (int g = 0; g < 20 && acc_cnt[0] < 1; g++) step();
        check("stall_first_beat", 64'(acc_cnt[0]), 64'd1);
        force_low = 4'b0001;
        repeat (5) step();
        force_low = '0;
        check("stall_no_accept", 64'(acc_cnt[0]), 64'd1);
        check("stall_no_steal1", 64'(acc_cnt[1]), 64'd0);
        check("stall_no_steal2", 64'(acc_cnt[2]), 64'd0);
        drain();
        check("stall_order", 64'((rsp_ids.size() == 3) ? rsp_ids[0] * 16 + rsp_ids[1] * 4 + rsp_ids[2] : -1),
              64'(0 * 16 + 1 * 4 + 2));

        // Reset in the middle of a transaction.
        do_reset(2, 1'b0);
        for (int b = 0; b < 4; b++) push_beat(3, 32'd100, 32'd0, b == 3);
        for (int g = 0; g < 20 && acc_cnt[3] < 2; g++) step();
        check("abort_two_beats", 64'(acc_cnt[3]), 64'd2);
        do_reset(2, 1'b1);
        push_beat(3, 32'd7, 32'd2, 1'b1);
        drain();
        check("abort_rsp_count", 64'(rsp_sums.size()), 64'd1);
        if (rsp_sums.size() == 1) check("abort_next_sum", 64'(rsp_sums[0]), 64'd5);

        // Two requesters continuously valid alternate.
        do_reset(2, 1'b0);
        for (int t = 0; t < 2; t++) begin
            push_beat(0, $urandom, $urandom, 1'b0);
            push_beat(0, $urandom, $urandom, 1'b1);
            push_beat(2, $urandom, $urandom, 1'b0);
            push_beat(2, $urandom, $urandom, 1'b1);
        end
        drain();
        check("fair_count", 64'(rsp_ids.size()), 64'd4);
        for (int i = 0; i < rsp_ids.size(); i++)
            check("fair_order", 64'(rsp_ids[i]), 64'((i % 2) * 2));

        // Randomized traffic with random stalls.
        stall_pct = 25;
        for (int batch = 0; batch < 3; batch++) begin
            for (int t = 0; t < 20; t++) begin
                id = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) push_beat(id, $urandom, $urandom, b == len - 1);
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
